// File: rtl/stfft_delay_line_pkg.sv
// Shared types and sizing helpers for the STFFT delay line.
package stfft_delay_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Which source the output register currently presents.
  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_BYP  = 2'd1,
    SRC_RAM  = 2'd2
  } src_e;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/stfft_delay_line_ram.sv
// 1R1W synchronous RAM with registered read; a read and write to the same
// address in one cycle returns the previous content.
module stfft_delay_ram
  import stfft_delay_pkg::*;
#(
  parameter int width_p = 32,
  parameter int depth_p = 512
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [ptr_w(depth_p)-1:0]   wr_addr,
  input  logic [width_p-1:0]          wr_data,
  input  logic                        re,
  input  logic [ptr_w(depth_p)-1:0]   rd_addr,
  output logic [width_p-1:0]          rd_data
);

  logic [width_p-1:0] mem [depth_p];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/stfft_delay_line.sv
// Programmable sample delay line (0..depth_p) with ready/valid handshake.
// Define STFFT_DELAY_ZERO_FILL_EN to emit zero samples during FILL.
module stfft_delay_line
  import stfft_delay_pkg::*;
#(
  parameter int width_p    = 16,
  parameter int depth_p    = 512,
  parameter int channels_p = 2
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  input  logic                          cfg_load_i,
  input  logic [$clog2(depth_p):0]      delay_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [channels_p*width_p-1:0] data_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [channels_p*width_p-1:0] data_o,
  output logic                          busy_o
);

  localparam int AW     = ptr_w(depth_p);
  localparam int DW     = AW + 1;
  localparam int DATA_W = channels_p * width_p;
  localparam logic [DW-1:0] DMAX = DW'(depth_p);

  state_e            state, state_nxt;
  src_e              src_q;
  logic [DW-1:0]     d_q, fill_cnt, dly_clamp;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [DATA_W-1:0] byp_q, ram_rd;
  logic              beat, fill_last, ram_we, ram_re;

  assign dly_clamp = (delay_i > DMAX) ? DMAX : delay_i;
  assign ready_o   = (state != IDLE) && (!valid_o || ready_i);
  assign beat      = valid_i && ready_o;
  assign busy_o    = (state == FILL);
  assign fill_last = ((fill_cnt + DW'(1)) == d_q);
  // D == depth_p truncates to zero offset: read the slot about to be overwritten.
  assign rd_ptr    = wr_ptr - d_q[AW-1:0];
  assign ram_we    = beat && !cfg_load_i && (d_q != '0);
  assign ram_re    = ram_we && (state == RUN);

  always_comb begin
    state_nxt = state;
    if (cfg_load_i)
      state_nxt = (dly_clamp == '0) ? RUN : FILL;
    else if (beat && state == FILL && fill_last)
      state_nxt = RUN;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) state <= IDLE;
    else           state <= state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      d_q      <= '0;
      fill_cnt <= '0;
      wr_ptr   <= '0;
      valid_o  <= 1'b0;
      src_q    <= SRC_ZERO;
      byp_q    <= '0;
    end else if (cfg_load_i) begin
      // A beat coinciding with a load is dropped along with any pending output.
      d_q      <= dly_clamp;
      fill_cnt <= '0;
      wr_ptr   <= '0;
      valid_o  <= 1'b0;
    end else if (beat) begin
      if (d_q != '0) wr_ptr <= wr_ptr + AW'(1);
      if (state == FILL) begin
        if (fill_cnt != d_q) fill_cnt <= fill_cnt + DW'(1);
`ifdef STFFT_DELAY_ZERO_FILL_EN
        valid_o <= 1'b1;
        src_q   <= SRC_ZERO;
`else
        valid_o <= 1'b0;
`endif
      end else if (d_q == '0) begin
        valid_o <= 1'b1;
        src_q   <= SRC_BYP;
        byp_q   <= data_i;
      end else begin
        valid_o <= 1'b1;
        src_q   <= SRC_RAM;
      end
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

  // RAM read data stays put while stalled because reads only fire on beats.
  always_comb begin
    data_o = '0;
    case (src_q)
      SRC_RAM: data_o = ram_rd;
      SRC_BYP: data_o = byp_q;
      default: data_o = '0;
    endcase
  end

  stfft_delay_ram #(
    .width_p (DATA_W),
    .depth_p (depth_p)
  ) u_ram (
    .clk     (clk_i),
    .we      (ram_we),
    .wr_addr (wr_ptr),
    .wr_data (data_i),
    .re      (ram_re),
    .rd_addr (rd_ptr),
    .rd_data (ram_rd)
  );

endmodule

// File: tb/tb_stfft_delay_line.sv
// Randomized + directed bench for stfft_delay_line against a beat-history model.
module tb_stfft_delay_line;

  localparam int W     = 16;
  localparam int DEPTH = 8;
  localparam int CH    = 2;
  localparam int DLW   = $clog2(DEPTH) + 1;

  logic           clk = 1'b0;
  logic           reset_ni, cfg_load_i, valid_i, ready_o, valid_o, ready_i, busy_o;
  logic [DLW-1:0] delay_i;
  logic [31:0]    data_i, data_o;

  always #5 clk = ~clk;

  stfft_delay_line #(.width_p(W), .depth_p(DEPTH), .channels_p(CH)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .cfg_load_i(cfg_load_i), .delay_i(delay_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i), .valid_o(valid_o),
    .ready_i(ready_i), .data_o(data_o), .busy_o(busy_o)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: history of beats since the last load; beat n yields beat n-D.
  logic [31:0] hist[$], expq[$], out_log[$];
  int          m_n = 0, m_d = 0;
  bit          m_loaded = 0, mon_en = 0, hold_prev = 0;
  logic [31:0] hold_data;

  always @(negedge clk) if (mon_en) begin
    chk("ready_o", ready_o, m_loaded && (!valid_o || ready_i));
    chk("busy_o", busy_o, m_loaded && (m_n < m_d));
    chk("valid_o", valid_o, expq.size() != 0);
    if (hold_prev) begin
      chk("hold_valid", valid_o, 1);
      chk("hold_data", data_o, hold_data);
    end
    if (valid_o && ready_i && expq.size() != 0) begin
      chk("data_o", data_o, expq.pop_front());
      out_log.push_back(data_o);
    end
    hold_prev = 0;
    if (!reset_ni) begin
      expq.delete(); hist.delete(); m_loaded = 0; m_n = 0; m_d = 0;
    end else if (cfg_load_i) begin
      expq.delete(); hist.delete(); m_loaded = 1; m_n = 0;
      m_d = (int'(delay_i) > DEPTH) ? DEPTH : int'(delay_i);
    end else begin
      if (valid_o && !ready_i) begin hold_prev = 1; hold_data = data_o; end
      if (valid_i && ready_o && m_loaded) begin
        hist.push_back(data_i);
        if (m_n >= m_d) expq.push_back(hist[m_n - m_d]);
`ifdef STFFT_DELAY_ZERO_FILL_EN
        else expq.push_back(32'd0);
`endif
        m_n++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    valid_i = 0; cfg_load_i = 0; ready_i = 1;
    repeat (n) tick();
  endtask

  task automatic load(input int d);
    cfg_load_i = 1; delay_i = DLW'(d);
    tick();
    cfg_load_i = 0;
  endtask

  task automatic stream(input logic [31:0] vals[$], input int stall_at, input int stall_len);
    int  k = 0, c = 0;
    bit  acc;
    while (k < vals.size() && c < 500) begin
      ready_i = !(c >= stall_at && c < stall_at + stall_len);
      valid_i = 1; data_i = vals[k];
      #1 acc = ready_o;
      @(posedge clk); #1;
      if (acc) k++;
      c++;
    end
    valid_i = 0; ready_i = 1;
    chk("stream_done", k, vals.size());
  endtask

  task automatic check_log(input string nm, input logic [31:0] e[$]);
    chk({nm, "_len"}, out_log.size(), e.size());
    for (int i = 0; i < e.size() && i < out_log.size(); i++) chk(nm, out_log[i], e[i]);
  endtask

  task automatic ramp(input int lo, input int hi, output logic [31:0] q[$]);
    q.delete();
    for (int i = lo; i <= hi; i++) q.push_back(32'(i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v[$], e[$];
    reset_ni = 0; cfg_load_i = 0; delay_i = '0; valid_i = 0; ready_i = 1; data_i = '0;
    tick();
    mon_en = 1;
    tick();
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_busy", busy_o, 0);
    reset_ni = 1;
    valid_i = 1; data_i = 32'h55;
    repeat (2) begin tick(); chk("idle_ready", ready_o, 0); end
    idle(1);

    // D=3 on depth 8
    load(3); out_log.delete();
    ramp(1, 6, v); stream(v, 1000, 0); idle(3);
`ifdef STFFT_DELAY_ZERO_FILL_EN
    e = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd2, 32'd3};
`else
    e = '{32'd1, 32'd2, 32'd3};
`endif
    check_log("d3", e);

    // D=0 bypass
    load(0); out_log.delete();
    ramp(10, 12, v); stream(v, 1000, 0); idle(3);
    e = '{32'd10, 32'd11, 32'd12};
    check_log("d0", e);

    // D=depth_p, stale RAM content from earlier runs must stay masked
    load(8); out_log.delete();
    ramp(1, 16, v); stream(v, 1000, 0); idle(3);
    e.delete();
`ifdef STFFT_DELAY_ZERO_FILL_EN
    for (int i = 0; i < 8; i++) e.push_back(32'd0);
`endif
    for (int i = 1; i <= 8; i++) e.push_back(32'(i));
    check_log("dmax", e);

    // Backpressure: 3-cycle stall while output pending
    load(2); out_log.delete();
    ramp(1, 6, v); stream(v, 3, 3); idle(3);
`ifdef STFFT_DELAY_ZERO_FILL_EN
    e = '{32'd0, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4};
`else
    e = '{32'd1, 32'd2, 32'd3, 32'd4};
`endif
    check_log("stall", e);

    // Reload 4 -> 1 mid-RUN with a coincident (discarded) beat
    load(4);
    ramp(1, 8, v); stream(v, 1000, 0);
    cfg_load_i = 1; delay_i = 1; valid_i = 1; data_i = 32'd99; ready_i = 1;
    tick();
    cfg_load_i = 0; valid_i = 0;
    out_log.delete();
    chk("reload_busy", busy_o, 1);
    chk("reload_valid", valid_o, 0);
    ramp(100, 102, v); stream(v, 1000, 0); idle(3);
    chk("reload_busy_end", busy_o, 0);
`ifdef STFFT_DELAY_ZERO_FILL_EN
    e = '{32'd0, 32'd100, 32'd101};
`else
    e = '{32'd100, 32'd101};
`endif
    check_log("reload", e);

    // Reset mid-stream with output pending
    load(2);
    ramp(1, 4, v); stream(v, 1000, 0);
    reset_ni = 0; valid_i = 1; data_i = 32'd7;
    tick();
    chk("mrst_valid", valid_o, 0);
    chk("mrst_data", data_o, 0);
    chk("mrst_ready", ready_o, 0);
    reset_ni = 1;
    repeat (3) begin tick(); chk("mrst_idle_ready", ready_o, 0); end
    valid_i = 0;
    load(1); out_log.delete();
    ramp(1, 3, v); stream(v, 1000, 0); idle(3);
`ifdef STFFT_DELAY_ZERO_FILL_EN
    e = '{32'd0, 32'd1, 32'd2};
`else
    e = '{32'd1, 32'd2};
`endif
    check_log("mrst", e);

    // Random delays (incl. clamped >depth), traffic, backpressure and reloads
    for (int r = 0; r < 30; r++) begin
      load($urandom_range(0, 15));
      for (int c = 0; c < 40; c++) begin
        valid_i    = ($urandom % 4) != 0;
        ready_i    = ($urandom % 4) != 0;
        data_i     = $urandom;
        cfg_load_i = ($urandom % 40) == 0;
        delay_i    = DLW'($urandom_range(0, 15));
        tick();
      end
      cfg_load_i = 0;
    end
    idle(4);
    chk("drained", valid_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stfft_delay_line.md
STFFT_DELAY_LINE -- requirements
Module: stfft_delay_line

Interface
REQ-001 SHALL have parameter width_p, default 16, bits per channel sample.
REQ-002 SHALL have parameter depth_p, default 512, maximum delay in samples (power of two, >=2).
REQ-003 SHALL have parameter channels_p, default 2, parallel channels sharing one delay (e.g. re/im).
REQ-004 SHALL have port clk_i  input  1  sole clock, all logic on posedge.
REQ-005 SHALL have port reset_ni  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port cfg_load_i  input  1  pulse: latch delay_i and restart the line.
REQ-007 SHALL have port delay_i  input  $clog2(depth_p)+1  requested delay D, 0..depth_p.
REQ-008 SHALL have port valid_i  input  1  input sample valid.
REQ-009 SHALL have port ready_o  output  1  line can accept a sample.
REQ-010 SHALL have port data_i  input  channels_p*width_p  input sample, channel 0 in LSBs.
REQ-011 SHALL have port valid_o  output  1  output sample valid.
REQ-012 SHALL have port ready_i  input  1  downstream accepts output.
REQ-013 SHALL have port data_o  output  channels_p*width_p  delayed sample.
REQ-014 SHALL have port busy_o  output  1  high while in FILL state.

Function
REQ-015 SHALL accept a sample on a cycle with valid_i && ready_o (a "beat").
REQ-016 SHALL drive ready_o = !valid_o || ready_i (single output register, no bubbles at full rate).
REQ-017 SHALL, for beat n, present output equal to input beat n-D, valid_o rising exactly 1 cycle after the beat.
REQ-018 SHALL write beat data at wr_ptr and read at wr_ptr-D mod depth_p in the same cycle; wr_ptr increments modulo depth_p per beat.
REQ-019 SHALL, for D=0, bypass the RAM and register data_i directly (1-cycle latency).
REQ-020 SHALL, for D=depth_p, read the location being overwritten and return the old content (read-before-write).
REQ-021 SHALL hold data_o and valid_o stable while valid_o && !ready_i.
REQ-022 SHALL implement states IDLE (after reset, no delay loaded), FILL (beats since load < D), RUN.
REQ-023 SHALL transition IDLE->FILL on cfg_load_i with D>0, IDLE->RUN on cfg_load_i with D=0, FILL->RUN on the D-th beat; cfg_load_i in any state restarts to FILL/RUN.
REQ-024 SHALL hold ready_o low in IDLE.
REQ-025 SHALL, on cfg_load_i coinciding with a beat, discard the beat and drop valid_o next cycle.
REQ-026 SHALL clamp delay_i > depth_p to depth_p.
REQ-027 SHALL count fill beats with a counter saturating at D.

Reset
REQ-028 SHALL, with reset_ni low at a clock edge: state IDLE, wr_ptr 0, fill count 0, valid_o 0, data_o 0, busy_o 0, latched D 0.
REQ-029 SHALL not clear RAM contents on reset; stale data never reaches data_o (FILL masks it).
REQ-030 SHALL abort any in-flight output when reset asserts mid-stream.

Configuration
REQ-031 SHALL, with STFFT_DELAY_ZERO_FILL_EN defined, emit valid_o for every FILL beat with data_o = 0.
REQ-032 SHALL, without STFFT_DELAY_ZERO_FILL_EN, suppress valid_o for FILL beats (first D beats produce no output).

Structure
REQ-033 SHALL place the state enum (IDLE/FILL/RUN) and a pointer-width helper function in package stfft_delay_pkg.
REQ-034 SHALL instantiate one sub-module stfft_delay_ram: 1R1W synchronous RAM, width channels_p*width_p, depth depth_p, read enable, registered read.

Verification
REQ-035 SHALL test: depth_p=8, load D=3, stream 1,2,3,4,5,6 continuous, ready_i=1 -> ZERO_FILL: 0,0,0,1,2,3; else: 1,2,3 after 3 silent beats.
REQ-036 SHALL test: D=0, stream 10,11,12 -> 10,11,12 each one cycle after its beat.
REQ-037 SHALL test: D=8 (=depth_p), stream 1..16 -> outputs 1..8 on beats 9..16.
REQ-038 SHALL test: D=2, RUN, ready_i low 3 cycles -> ready_o low, data_o frozen, no sample lost or duplicated after release.
REQ-039 SHALL test: cfg_load_i D=4->1 mid-RUN -> busy_o high for 1 beat, next output is first post-load sample (or 0 with ZERO_FILL).
REQ-040 SHALL test: reset_ni low mid-stream -> next cycle valid_o=0, data_o=0, ready_o=0 until cfg_load_i.
